// File: rtl/prog_fir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_fir_pkg                                                     |
// | Shared constants and types for the FIR coefficient bank.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package prog_fir_pkg;

  localparam int CTRL_OFFSET     = 0;
  localparam int CTRL_SWAP_BIT   = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int STAT_PEND_BIT   = 0;
  localparam int STAT_ACTIVE_BIT = 1;
  localparam int STAT_ERR_BIT    = 2;
  localparam int STAT_CNT_LSB    = 16;

  localparam int DEF_COEFF_W = 16;
  typedef logic signed [DEF_COEFF_W-1:0] coeff_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage
`default_nettype wire

// File: rtl/coeff_bank_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coeff_bank_mem                                                   |
// | One coefficient bank: a row per channel, per-tap write select,   |
// | registered row read. Second read port when                       |
// | PROG_FIR_COEFF_READBACK_EN is defined.                           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module coeff_bank_mem #(
  parameter int N_CHAN  = 256,
  parameter int N_TAPS  = 20,
  parameter int COEFF_W = 16,
  parameter int CH_W    = 8,
  parameter int TAP_W   = 5
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [CH_W-1:0]           i_waddr,
  input  logic [TAP_W-1:0]          i_wtap,
  input  logic [COEFF_W-1:0]        i_wdata,
  input  logic [CH_W-1:0]           i_raddr,
  output logic [N_TAPS*COEFF_W-1:0] o_rdata
`ifdef PROG_FIR_COEFF_READBACK_EN
  ,
  input  logic [CH_W-1:0]           i_raddr_b,
  output logic [N_TAPS*COEFF_W-1:0] o_rdata_b
`endif
);

  localparam int ROW_W = N_TAPS*COEFF_W;

  logic [ROW_W-1:0] r_mem [N_CHAN];
  logic [ROW_W-1:0] r_rdata;

  // Contents are intentionally not reset; reads see pre-write data.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int t = 0; t < N_TAPS; t++) begin
        if (i_wtap == TAP_W'(t)) begin
          r_mem[i_waddr][t*COEFF_W +: COEFF_W] <= i_wdata;
        end
      end
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

`ifdef PROG_FIR_COEFF_READBACK_EN
  logic [ROW_W-1:0] r_rdata_b;

  always_ff @(posedge clk) begin
    r_rdata_b <= r_mem[i_raddr_b];
  end

  assign o_rdata_b = r_rdata_b;
`endif

endmodule
`default_nettype wire

// File: rtl/prog_fir_coeff_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog_fir_coeff_bank                                              |
// | Double-buffered per-channel FIR coefficient store with frame-    |
// | aligned bank swap. Optional: PROG_FIR_COEFF_READBACK_EN.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module prog_fir_coeff_bank
  import prog_fir_pkg::*;
#(
  parameter int N_CHAN  = 256,
  parameter int N_TAPS  = 20,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int CH_W    = $clog2(N_CHAN),
  parameter int AW      = $clog2(N_CHAN*N_TAPS)+1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_bram_en_a,
  input  logic                      i_bram_we,
  input  logic [AW-1:0]             i_bram_addr,
  input  logic [31:0]               i_bram_wr_data,
  output logic [31:0]               o_bram_rd_data,
  input  logic                      i_sync_in,
  input  logic                      i_ch_valid,
  input  logic [CH_W-1:0]           i_ch_in,
  output logic [N_TAPS*COEFF_W-1:0] o_coeffs_out,
  output logic                      o_coeffs_valid,
  output logic                      o_swap_pulse
);

  localparam int TAP_W   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int ROW_W   = N_TAPS*COEFF_W;
  localparam int N_WORDS = N_CHAN*N_TAPS;

  swap_state_t      r_state;
  logic             r_active;
  logic             r_err_oob;
  logic             r_swap_pulse;
  logic [15:0]      r_swap_count;

  logic             r_s1_valid;
  logic             r_s1_bank;
  logic             r_s1_zero;
  logic             r_coeffs_valid;
  logic [ROW_W-1:0] r_coeffs;

  logic             r_rd_req;
  logic             r_rd_ctrl;
  logic [31:0]      r_rd_word;
  logic [31:0]      r_rd_data;

  logic             w_wr;
  logic             w_rd;
  logic             w_is_ctrl;
  logic [31:0]      w_off;
  logic             w_in_range;
  logic             w_ctrl_hit;
  logic             w_coef_we;
  logic             w_oob_set;
  logic             w_swap_req;
  logic             w_err_clr;
  logic             w_do_swap;
  logic             w_look_bank;
  logic             w_ch_ok;
  logic [CH_W-1:0]  w_wch;
  logic [TAP_W-1:0] w_wtap;
  logic [31:0]      w_ctrl_word;
  logic [31:0]      w_rd_val;
  logic [ROW_W-1:0] w_look_row;
  logic [ROW_W-1:0] w_row [2];
  logic             w_unused_wr;

  assign w_unused_wr = ^i_bram_wr_data;

  always_comb begin
    w_wr       = i_bram_en_a & i_bram_we;
    w_rd       = i_bram_en_a & ~i_bram_we;
    w_is_ctrl  = i_bram_addr[AW-1];
    w_off      = 32'(i_bram_addr[AW-2:0]);
    w_in_range = w_off < 32'(N_WORDS);
    w_ctrl_hit = w_is_ctrl & (w_off == 32'(CTRL_OFFSET));
    w_wch      = CH_W'(w_off / 32'(N_TAPS));
    w_wtap     = TAP_W'(w_off % 32'(N_TAPS));
    w_coef_we  = w_wr & ~w_is_ctrl & w_in_range;
    w_oob_set  = w_wr & ~w_is_ctrl & ~w_in_range;
    w_swap_req = w_wr & w_ctrl_hit & i_bram_wr_data[CTRL_SWAP_BIT];
    w_err_clr  = w_wr & w_ctrl_hit & i_bram_wr_data[CTRL_CLR_BIT];
    w_do_swap  = (r_state == PENDING) & i_sync_in;
    // A lookup in the swap cycle must already see the incoming bank.
    w_look_bank = r_active ^ w_do_swap;
    w_ch_ok     = 32'(i_ch_in) < 32'(N_CHAN);
    w_look_row  = r_s1_bank ? w_row[1] : w_row[0];
  end

  always_comb begin
    w_ctrl_word                      = '0;
    w_ctrl_word[STAT_PEND_BIT]       = (r_state == PENDING);
    w_ctrl_word[STAT_ACTIVE_BIT]     = r_active;
    w_ctrl_word[STAT_ERR_BIT]        = r_err_oob;
    w_ctrl_word[STAT_CNT_LSB +: 16]  = r_swap_count;
  end

`ifdef PROG_FIR_COEFF_READBACK_EN
  logic               r_rd_coef;
  logic [TAP_W-1:0]   r_rd_tap;
  logic               r_rd_bank;
  logic [ROW_W-1:0]   w_row_b [2];
  logic [ROW_W-1:0]   w_rb_row;
  logic [COEFF_W-1:0] w_rb_coef;

  always_comb begin
    w_rb_row  = r_rd_bank ? w_row_b[1] : w_row_b[0];
    w_rb_coef = w_rb_row[r_rd_tap*COEFF_W +: COEFF_W];
  end
`endif

  always_comb begin
    w_rd_val = '0;
    if (r_rd_ctrl) begin
      w_rd_val = r_rd_word;
    end
`ifdef PROG_FIR_COEFF_READBACK_EN
    else if (r_rd_coef) begin
      w_rd_val = 32'($signed(w_rb_coef));
    end
`endif
  end

  // Only the shadow bank (not r_active) accepts writes.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    coeff_bank_mem #(
      .N_CHAN  (N_CHAN),
      .N_TAPS  (N_TAPS),
      .COEFF_W (COEFF_W),
      .CH_W    (CH_W),
      .TAP_W   (TAP_W)
    ) u_mem (
      .clk       (clk),
      .i_we      (w_coef_we & (r_active != 1'(b))),
      .i_waddr   (w_wch),
      .i_wtap    (w_wtap),
      .i_wdata   (i_bram_wr_data[COEFF_W-1:0]),
      .i_raddr   (i_ch_in),
      .o_rdata   (w_row[b])
`ifdef PROG_FIR_COEFF_READBACK_EN
      ,
      .i_raddr_b (w_wch),
      .o_rdata_b (w_row_b[b])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_active     <= 1'b0;
      r_swap_count <= '0;
      r_swap_pulse <= 1'b0;
    end else begin
      r_swap_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_swap_req) r_state <= PENDING;
        end
        PENDING: begin
          if (i_sync_in) begin
            r_state      <= IDLE;
            r_active     <= ~r_active;
            r_swap_count <= r_swap_count + 16'd1;
            r_swap_pulse <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_oob <= 1'b0;
    end else if (w_oob_set) begin
      r_err_oob <= 1'b1;
    end else if (w_err_clr) begin
      r_err_oob <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid     <= 1'b0;
      r_s1_bank      <= 1'b0;
      r_s1_zero      <= 1'b0;
      r_coeffs_valid <= 1'b0;
      r_coeffs       <= '0;
    end else begin
      r_s1_valid     <= i_ch_valid;
      r_s1_bank      <= w_look_bank;
      r_s1_zero      <= ~w_ch_ok;
      r_coeffs_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_coeffs <= r_s1_zero ? '0 : w_look_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_req  <= 1'b0;
      r_rd_ctrl <= 1'b0;
      r_rd_word <= '0;
      r_rd_data <= '0;
`ifdef PROG_FIR_COEFF_READBACK_EN
      r_rd_coef <= 1'b0;
      r_rd_tap  <= '0;
      r_rd_bank <= 1'b0;
`endif
    end else begin
      r_rd_req  <= w_rd;
      r_rd_ctrl <= w_rd & w_ctrl_hit;
      r_rd_word <= w_ctrl_word;
`ifdef PROG_FIR_COEFF_READBACK_EN
      r_rd_coef <= w_rd & ~w_is_ctrl & w_in_range;
      r_rd_tap  <= w_wtap;
      r_rd_bank <= ~r_active;
`endif
      if (r_rd_req) begin
        r_rd_data <= w_rd_val;
      end
    end
  end

  assign o_bram_rd_data = r_rd_data;
  assign o_coeffs_out   = r_coeffs;
  assign o_coeffs_valid = r_coeffs_valid;
  assign o_swap_pulse   = r_swap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_prog_fir_coeff_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_prog_fir_coeff_bank                                           |
// | Self-checking bench: directed table, corner sequences, random.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_prog_fir_coeff_bank;
  import prog_fir_pkg::*;

  localparam int N_CHAN  = 256;
  localparam int N_TAPS  = 20;
  localparam int COEFF_W = 16;
  localparam int CH_W    = $clog2(N_CHAN);
  localparam int AW      = $clog2(N_CHAN*N_TAPS)+1;
  localparam int ROW_W   = N_TAPS*COEFF_W;
  localparam int N_WORDS = N_CHAN*N_TAPS;
  localparam logic [AW-1:0] CTRL_ADDR = {1'b1, {(AW-1){1'b0}}};

  localparam int K_WR = 0, K_RD = 1, K_LOOK = 2, K_SYNC = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en, we, sync, chv;
  logic [AW-1:0]    addr;
  logic [31:0]      wdata;
  logic [CH_W-1:0]  ch;
  logic [31:0]      rd_data;
  logic [ROW_W-1:0] coeffs;
  logic             cvalid, spulse;

  always #5 clk = ~clk;

  prog_fir_coeff_bank #(
    .N_CHAN(N_CHAN), .N_TAPS(N_TAPS), .COEFF_W(COEFF_W), .CH_W(CH_W), .AW(AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_bram_en_a    (en),
    .i_bram_we      (we),
    .i_bram_addr    (addr),
    .i_bram_wr_data (wdata),
    .o_bram_rd_data (rd_data),
    .i_sync_in      (sync),
    .i_ch_valid     (chv),
    .i_ch_in        (ch),
    .o_coeffs_out   (coeffs),
    .o_coeffs_valid (cvalid),
    .o_swap_pulse   (spulse)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;

  // Reference model: two banks, one of them active, software sees the other.
  logic [COEFF_W-1:0] m_bank [2][N_CHAN][N_TAPS];
  int m_active, m_pending, m_err, m_count;

  typedef struct { int due; logic [ROW_W-1:0] row; } look_t;
  typedef struct { int due; logic [31:0] data; } rd_t;
  look_t look_q[$];
  rd_t   rd_q[$];

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    logic [31:0] data;
    int          ch;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] caddr(input int c, input int t);
    return AW'(c*N_TAPS + t);
  endfunction

  function automatic logic [ROW_W-1:0] model_row(input int b, input int c);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < N_TAPS; k++) r[k*COEFF_W +: COEFF_W] = m_bank[b][c][k];
    return r;
  endfunction

  function automatic logic [31:0] ctrl_val();
    return ((32'(m_count) & 32'hFFFF) << 16) | (32'(m_err) << 2) |
           (32'(m_active) << 1) | 32'(m_pending);
  endfunction

  task automatic set_idle();
    en = 0; we = 0; addr = '0; wdata = '0; sync = 0; chv = 0; ch = '0;
  endtask

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_err = 0; m_count = 0;
    look_q.delete();
    rd_q.delete();
  endtask

  // One clock: update the model from the current inputs, clock, then compare.
  task automatic step();
    int off, b;
    logic [31:0] rv;
    logic swap, req, exp_pulse, exp_valid;
    swap = (m_pending != 0) && sync;
    req  = 1'b0;
    off  = int'(addr[AW-2:0]);
    if (chv) begin
      b = swap ? 1 - m_active : m_active;
      look_q.push_back('{cyc + 2, (int'(ch) < N_CHAN) ? model_row(b, int'(ch)) : '0});
    end
    if (en && !we) begin
      rv = '0;
      if (addr[AW-1]) begin
        if (off == 0) rv = ctrl_val();
      end else begin
`ifdef PROG_FIR_COEFF_READBACK_EN
        if (off < N_WORDS) rv = 32'($signed(m_bank[1-m_active][off/N_TAPS][off%N_TAPS]));
`endif
      end
      rd_q.push_back('{cyc + 2, rv});
    end
    if (en && we) begin
      if (!addr[AW-1]) begin
        if (off < N_WORDS) m_bank[1-m_active][off/N_TAPS][off%N_TAPS] = wdata[COEFF_W-1:0];
        else m_err = 1;
      end else if (off == 0) begin
        if (wdata[1]) m_err = 0;
        if (wdata[0]) req = 1'b1;
      end
    end
    if (swap) begin
      m_active  = 1 - m_active;
      m_count   = (m_count + 1) & 16'hFFFF;
      m_pending = 0;
    end else if (req) begin
      m_pending = 1;
    end
    exp_pulse = swap;

    @(posedge clk);
    #1;
    cyc++;

    exp_valid = (look_q.size() > 0) && (look_q[0].due == cyc);
    chk("coeffs_valid", ROW_W'(cvalid), ROW_W'(exp_valid));
    if (cvalid) valid_cnt++;
    if (exp_valid) begin
      chk("coeffs_out", coeffs, look_q[0].row);
      void'(look_q.pop_front());
    end
    if ((rd_q.size() > 0) && (rd_q[0].due == cyc)) begin
      chk("bram_rd_data", ROW_W'(rd_data), ROW_W'(rd_q[0].data));
      void'(rd_q.pop_front());
    end
    chk("swap_pulse", ROW_W'(spulse), ROW_W'(exp_pulse));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    set_idle(); en = 1; we = 1; addr = a; wdata = d; step(); set_idle();
  endtask

  task automatic rd_wait(input logic [AW-1:0] a);
    set_idle(); en = 1; addr = a; step(); set_idle(); step();
  endtask

  initial begin
    int pulses;
    logic [31:0] rb_exp;

    for (int b = 0; b < 2; b++)
      for (int c = 0; c < N_CHAN; c++)
        for (int t = 0; t < N_TAPS; t++) m_bank[b][c][t] = '0;
    model_reset();
    set_idle();

`ifdef PROG_FIR_COEFF_READBACK_EN
    rb_exp = 32'hFFFF_8001;
`else
    rb_exp = 32'h0;
`endif

    vecs[0]  = '{K_RD,   CTRL_ADDR,           32'h0,    0, 32'h0000_0000, 32'h0};
    vecs[1]  = '{K_LOOK, '0,                  32'h0,    5, 32'h0,         32'h0};
    vecs[2]  = '{K_WR,   caddr(3, 0),         32'h1234, 0, 32'h0,         32'h0};
    vecs[3]  = '{K_WR,   caddr(3, N_TAPS-1),  32'hFFFF, 0, 32'h0,         32'h0};
    vecs[4]  = '{K_WR,   CTRL_ADDR,           32'h1,    0, 32'h0,         32'h0};
    vecs[5]  = '{K_RD,   CTRL_ADDR,           32'h0,    0, 32'h0000_0001, 32'h0};
    vecs[6]  = '{K_SYNC, '0,                  32'h0,    0, 32'h0,         32'h0};
    vecs[7]  = '{K_LOOK, '0,                  32'h0,    3, 32'h1234,      32'hFFFF};
    vecs[8]  = '{K_RD,   CTRL_ADDR,           32'h0,    0, 32'h0001_0002, 32'h0};
    vecs[9]  = '{K_WR,   AW'(N_WORDS),        32'h5555, 0, 32'h0,         32'h0};
    vecs[10] = '{K_RD,   CTRL_ADDR,           32'h0,    0, 32'h0001_0006, 32'h0};
    vecs[11] = '{K_WR,   CTRL_ADDR,           32'h2,    0, 32'h0,         32'h0};
    vecs[12] = '{K_RD,   CTRL_ADDR,           32'h0,    0, 32'h0001_0002, 32'h0};
    vecs[13] = '{K_WR,   caddr(7, 2),         32'h8001, 0, 32'h0,         32'h0};
    vecs[14] = '{K_RD,   caddr(7, 2),         32'h0,    0, rb_exp,        32'h0};

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", ROW_W'(rd_data), '0);
    chk("reset_coeffs", coeffs, '0);
    chk("reset_valid", ROW_W'(cvalid), '0);
    chk("reset_pulse", ROW_W'(spulse), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      set_idle();
      case (vecs[i].kind)
        K_WR:   begin en = 1; we = 1; addr = vecs[i].addr; wdata = vecs[i].data; end
        K_RD:   begin en = 1; addr = vecs[i].addr; end
        K_LOOK: begin chv = 1; ch = CH_W'(vecs[i].ch); end
        default: begin chv = 1; ch = '0; sync = 1; end
      endcase
      step();
      set_idle();
      step();
      if (vecs[i].kind == K_RD)
        chk($sformatf("vec%0d_rd", i), ROW_W'(rd_data), ROW_W'(vecs[i].exp0));
      if (vecs[i].kind == K_LOOK || vecs[i].kind == K_SYNC) begin
        chk($sformatf("vec%0d_tap0", i), ROW_W'(coeffs[0 +: COEFF_W]), ROW_W'(vecs[i].exp0[COEFF_W-1:0]));
        chk($sformatf("vec%0d_tapN", i), ROW_W'(coeffs[(N_TAPS-1)*COEFF_W +: COEFF_W]),
            ROW_W'(vecs[i].exp1[COEFF_W-1:0]));
      end
    end

    // Swap held pending for 100 cycles without a frame start
    wr(caddr(10, 0), 32'h0777);
    wr(CTRL_ADDR, 32'h1);
    for (int i = 0; i < 100; i++) begin
      set_idle(); chv = 1; ch = CH_W'(10 + (i % 3)); step();
    end
    set_idle();
    rd_wait(CTRL_ADDR);
    chk("pending_held", ROW_W'(rd_data[0]), ROW_W'(1'b1));
    set_idle(); sync = 1; chv = 1; ch = '0; step();
    pulses = spulse ? 1 : 0;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      if (spulse) pulses++;
    end
    chk("pulse_count", ROW_W'(pulses), ROW_W'(1));
    rd_wait(CTRL_ADDR);
    chk("pending_clear", ROW_W'(rd_data[0]), '0);

    // Back-to-back sweep of every channel after a fresh commit
    for (int i = 0; i < 400; i++)
      wr(caddr($urandom_range(0, N_CHAN-1), $urandom_range(0, N_TAPS-1)), $urandom);
    wr(CTRL_ADDR, 32'h1);
    valid_cnt = 0;
    for (int c = 0; c < N_CHAN; c++) begin
      set_idle(); chv = 1; ch = CH_W'(c); sync = (c == 0); step();
    end
    set_idle();
    repeat (3) step();
    chk("sweep_valid_cycles", ROW_W'(valid_cnt), ROW_W'(N_CHAN));

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      set_idle();
      if ($urandom_range(0, 99) < 5) begin
        sync = 1; chv = 1; ch = '0;
      end else if ($urandom_range(0, 99) < 70) begin
        chv = 1; ch = CH_W'($urandom_range(0, N_CHAN-1));
      end
      if ($urandom_range(0, 99) < 40) begin
        en = 1;
        we = ($urandom_range(0, 99) < 60);
        case ($urandom_range(0, 9))
          0, 1:    begin addr = CTRL_ADDR | AW'($urandom_range(0, 2)); wdata = 32'($urandom_range(0, 3)); end
          2:       begin addr = AW'($urandom_range(N_WORDS, (1 << (AW-1)) - 1)); wdata = $urandom; end
          default: begin addr = AW'($urandom_range(0, N_WORDS-1)); wdata = $urandom; end
        endcase
      end
      step();
    end
    set_idle();
    repeat (3) step();

    // Reset in the middle of a pending swap with lookups in flight
    wr(CTRL_ADDR, 32'h1);
    for (int i = 0; i < 2; i++) begin
      set_idle(); chv = 1; ch = CH_W'(i); en = 1; addr = CTRL_ADDR; step();
    end
    set_idle();
    rst_n = 1'b0;
    #2;
    chk("midreset_valid", ROW_W'(cvalid), '0);
    chk("midreset_coeffs", coeffs, '0);
    chk("midreset_rd_data", ROW_W'(rd_data), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();
    rd_wait(CTRL_ADDR);
    chk("midreset_ctrl", ROW_W'(rd_data), '0);
    set_idle(); chv = 1; ch = CH_W'(3); step();
    set_idle(); repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
